// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target with a 16x8 register file and an
// auto-incrementing register pointer. SCL/SDA are oversampled on clk; the
// target never stretches SCL and only ever pulls SDA low (open-drain).
//
// Bus protocol: START, {addr,R/W}, ACK; for writes the first byte loads the
// pointer and following bytes are stored at the pointer (pointer increments
// with wrap). For reads the target returns reg[ptr] bytes until the master
// NACKs. The pointer persists across transactions.
//
// Ports:
//   clk        system clock (>= 8x SCL rate)
//   rst        asynchronous active-high reset
//   scl_i      bus SCL level
//   sda_i      bus SDA level
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_addr   host-side read address
//   reg_rdata  combinational reg[reg_addr]
//   wr_strobe  one-clk pulse when a bus write updates a register
//   wr_addr    register written, valid with wr_strobe
//   busy       high from START until STOP
//
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN
//   defined   : 3-sample majority filter on synchronized SCL/SDA (single-clk
//               pulses rejected, 2 clk extra input latency)
//   undefined : edge detection runs directly on the synchronizer output
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h3C,
    parameter int         REG_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oe,
    input  logic [REG_DEPTH_LOG2-1:0] reg_addr,
    output logic [7:0]                reg_rdata,
    output logic                      wr_strobe,
    output logic [REG_DEPTH_LOG2-1:0] wr_addr,
    output logic                      busy
);
    localparam int NREGS = 1 << REG_DEPTH_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK
    } state_t;

    // ---------------- input conditioning ----------------
    // Synchronizers reset to 1 (idle bus level) so reset release never
    // looks like a bus edge.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_f, sda_f;
    logic       scl_prev_q, sda_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    assign scl_f = maj3(scl_hist_q);
    assign sda_f = maj3(sda_hist_q);
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    // SCL must be high in both samples so an SDA change right at an SCL
    // edge is treated as data, not as a bus condition.
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    // ---------------- protocol FSM ----------------
    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic                      rw_q, rw_d;
    logic [REG_DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                      sda_oe_q, sda_oe_d;
    logic                      busy_q, busy_d;
    logic                      wr_strobe_q, wr_strobe_d;
    logic [REG_DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]                regs_q [NREGS];
    logic [7:0]                regs_d [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;

        if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_f};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        // Full byte received; act on it as the ACK slot opens.
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                rw_d     = shift_q[0];
                                sda_oe_d = 1'b1;
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                state_d  = ST_IDLE;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d    = shift_q[REG_DEPTH_LOG2-1:0];
                            sda_oe_d = 1'b1;
                            state_d  = ST_WR_ACK;
                        end else begin
                            regs_d[ptr_q] = shift_q;
                            wr_strobe_d   = 1'b1;
                            wr_addr_d     = ptr_q;
                            ptr_d         = ptr_q + 1'b1;
                            sda_oe_d      = 1'b1;
                            state_d       = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            // Read: the ACK release edge also presents bit 7.
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            cnt_d    = 4'd1;
                            state_d  = ST_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_PTR;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // cnt_q counts bits already presented on the bus.
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            cnt_d    = 4'd1;
                        end else if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                        if (!sda_f) begin
                            cnt_d   = '0;
                            state_d = ST_RD_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign reg_rdata = regs_q[reg_addr];

endmodule
